// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register placed directly in front of the ALU. Each cycle it
// takes one decoded instruction plus register-file read data and:
//   - resolves RAW hazards by forwarding from EX, MEM and WB (EX highest),
//   - selects ALU operand A (PC or rs1) and operand B (immediate or rs2),
//   - registers the operands, store data, ALU select and control bits,
//   - detects a load-use hazard against the instruction currently held here,
//     stalls decode for one cycle and inserts a bubble.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   id_valid / id_ready         decode handshake (id_ready is combinational)
//   id_rs1, id_rs2, id_rd       register indices
//   id_rs1_used, id_rs2_used    instruction actually reads rs1 / rs2
//   id_rs1_data, id_rs2_data    register-file read data
//   id_pc, id_imm               PC and sign-extended immediate
//   id_use_pc, id_use_imm       operand A = PC, operand B = immediate
//   id_alu_sel                  ALU operation code
//   id_reg_write, id_mem_read, id_mem_write   control bits
//   ex_alu_result               ALU output for the instruction held here
//   mem_rd, mem_reg_write, mem_result         MEM-stage forwarding source
//   wb_rd, wb_reg_write, wb_result            WB-stage forwarding source
//   hold                        downstream stall, freeze contents
//   flush                       redirect, kill contents
//   ex_*                        registered ID/EX contents
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_use_pc,
    input  logic                      id_use_imm,
    input  logic [SEL_WIDTH-1:0]      id_alu_sel,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,

    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      mem_reg_write,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      wb_reg_write,
    input  logic [DATA_WIDTH-1:0]     wb_result,

    input  logic                      hold,
    input  logic                      flush,

    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_data_a,
    output logic [DATA_WIDTH-1:0]     ex_data_b,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [SEL_WIDTH-1:0]      ex_alu_sel,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write
);

    // Registered ID/EX contents
    logic                      valid_reg;
    logic [DATA_WIDTH-1:0]     data_a_reg;
    logic [DATA_WIDTH-1:0]     data_b_reg;
    logic [DATA_WIDTH-1:0]     store_data_reg;
    logic [SEL_WIDTH-1:0]      alu_sel_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_reg;
    logic                      reg_write_reg;
    logic                      mem_read_reg;
    logic                      mem_write_reg;

    // Source operands indexed 0 = rs1, 1 = rs2 so both share one forwarding mux
    logic [REG_ADDR_WIDTH-1:0] src_idx [2];
    logic [DATA_WIDTH-1:0]     src_data[2];
    logic                      src_used[2];
    logic [DATA_WIDTH-1:0]     fwd_data[2];
    logic                      src_load_hit[2];

    logic                      ex_fwd_ok;
    logic                      load_use;
    logic [DATA_WIDTH-1:0]     data_a_next;
    logic [DATA_WIDTH-1:0]     data_b_next;

    assign src_idx[0]  = id_rs1;
    assign src_idx[1]  = id_rs2;
    assign src_data[0] = id_rs1_data;
    assign src_data[1] = id_rs2_data;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    // A load held here has no data yet, so it can never be an EX forward source;
    // that case is covered by the load-use stall instead.
    assign ex_fwd_ok = valid_reg && reg_write_reg && !mem_read_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            always_comb begin
                fwd_data[gi] = src_data[gi];
                if (src_idx[gi] == '0) begin
                    fwd_data[gi] = '0;
                end else if (ex_fwd_ok && rd_reg == src_idx[gi]) begin
                    fwd_data[gi] = ex_alu_result;
                end else if (mem_reg_write && mem_rd == src_idx[gi]) begin
                    fwd_data[gi] = mem_result;
                end else if (wb_reg_write && wb_rd == src_idx[gi]) begin
                    fwd_data[gi] = wb_result;
                end
            end

            assign src_load_hit[gi] = src_used[gi] && (src_idx[gi] == rd_reg);
        end
    endgenerate

    assign load_use = id_valid && valid_reg && mem_read_reg && (rd_reg != '0) &&
                      (src_load_hit[0] || src_load_hit[1]);

    assign id_ready = !hold && !load_use;

    assign data_a_next = id_use_pc  ? id_pc  : fwd_data[0];
    assign data_b_next = id_use_imm ? id_imm : fwd_data[1];

    // Flush beats hold; a load-use bubble only applies when not held.
    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && load_use)) begin
            valid_reg      <= 1'b0;
            data_a_reg     <= '0;
            data_b_reg     <= '0;
            store_data_reg <= '0;
            alu_sel_reg    <= '0;
            rd_reg         <= '0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
        end else if (!hold) begin
            valid_reg      <= id_valid;
            data_a_reg     <= data_a_next;
            data_b_reg     <= data_b_next;
            store_data_reg <= fwd_data[1];
            alu_sel_reg    <= id_alu_sel;
            rd_reg         <= id_rd;
            reg_write_reg  <= id_valid && id_reg_write;
            mem_read_reg   <= id_valid && id_mem_read;
            mem_write_reg  <= id_valid && id_mem_write;
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_data_a     = data_a_reg;
    assign ex_data_b     = data_b_reg;
    assign ex_store_data = store_data_reg;
    assign ex_alu_sel    = alu_sel_reg;
    assign ex_rd         = rd_reg;
    assign ex_reg_write  = reg_write_reg;
    assign ex_mem_read   = mem_read_reg;
    assign ex_mem_write  = mem_write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used;
    logic [31:0] id_rs1_data, id_rs2_data, id_pc, id_imm;
    logic        id_use_pc, id_use_imm;
    logic [3:0]  id_alu_sel;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [31:0] ex_alu_result;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        hold, flush;
    logic        ex_valid;
    logic [31:0] ex_data_a, ex_data_b, ex_store_data;
    logic [3:0]  ex_alu_sel;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } ex_t;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .SEL_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
        .id_alu_sel(id_alu_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_alu_result(ex_alu_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_data_a(ex_data_a), .ex_data_b(ex_data_b),
        .ex_store_data(ex_store_data), .ex_alu_sel(ex_alu_sel), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    function automatic ex_t dut_state();
        ex_t s;
        s = {ex_valid, ex_data_a, ex_data_b, ex_store_data, ex_alu_sel, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 0; hold = 0; flush = 0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_pc = 0; id_imm = 0;
        id_use_pc = 0; id_use_imm = 0; id_alu_sel = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        ex_alu_result = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
        mem_result = 0; wb_result = 0;
    endtask

    task automatic randomize_id();
        id_valid     = 1'($urandom);
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_rd        = 5'($urandom_range(0, 3));
        id_rs1_used  = 1'($urandom);
        id_rs2_used  = 1'($urandom);
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_pc        = $urandom;
        id_imm       = $urandom;
        id_use_pc    = 1'($urandom);
        id_use_imm   = 1'($urandom);
        id_alu_sel   = 4'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_mem_write = 1'($urandom);
    endtask

    task automatic show(input string name);
        $display("%0t %s: ready=%0b ex_valid=%0b a=%h b=%h st=%h sel=%h rd=%0d rw/mr/mw=%0b%0b%0b",
                 $time, name, id_ready, ex_valid, ex_data_a, ex_data_b, ex_store_data,
                 ex_alu_sel, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write);
    endtask

    // ---------------- reference model ----------------
    // Value an instruction would read for source index idx, given what the
    // model says is currently held in EX and the later-stage inputs.
    function automatic logic [31:0] ref_fwd(input ex_t m, input logic [4:0] idx,
                                            input logic [31:0] rf);
        if (idx == 0) return 32'h0;
        if (m.valid && m.rw && !m.mr && m.rd == idx) return ex_alu_result;
        if (mem_reg_write && mem_rd == idx) return mem_result;
        if (wb_reg_write && wb_rd == idx) return wb_result;
        return rf;
    endfunction

    function automatic logic ref_load_use(input ex_t m);
        return id_valid && m.valid && m.mr && m.rd != 0 &&
               ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
    endfunction

    function automatic ex_t ref_next(input ex_t m);
        ex_t n;
        n = '0;
        if (rst || flush) return n;
        if (hold) return m;
        if (ref_load_use(m)) return n;
        n.valid = id_valid;
        n.a     = id_use_pc ? id_pc : ref_fwd(m, id_rs1, id_rs1_data);
        n.st    = ref_fwd(m, id_rs2, id_rs2_data);
        n.b     = id_use_imm ? id_imm : n.st;
        n.sel   = id_alu_sel;
        n.rd    = id_rd;
        n.rw    = id_valid & id_reg_write;
        n.mr    = id_valid & id_mem_read;
        n.mw    = id_valid & id_mem_write;
        return n;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        quiet_inputs();
        rst = 1;
        randomize_id();
        id_valid = 1;
        tick();
        randomize_id();
        id_valid = 1;
        tick();
        show("reset");
        checks++;
        if (dut_state() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", dut_state());
        end
        rst = 0;
        id_valid = 0;
        tick();
        show("reset_release");
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
            ex_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid/rw/mr/mw=%0b%0b%0b%0b expected 0000",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write);
        end
    endtask

    task automatic test_ex_forwarding();
        quiet_inputs();
        id_valid = 1; id_rd = 5; id_reg_write = 1; id_alu_sel = 4'h1;
        tick();
        show("ex_fwd_add");
        ex_alu_result = 32'h0000_0030;
        id_rd = 6; id_rs1 = 5; id_rs1_used = 1; id_rs1_data = 32'h11;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            errors++;
            $display("FAIL ex_fwd_ready: got %0b expected 1", id_ready);
        end
        tick();
        show("ex_fwd_use");
        checks++;
        if (ex_data_a !== 32'h30) begin
            errors++;
            $display("FAIL ex_fwd_data_a: got %h expected 00000030", ex_data_a);
        end
    endtask

    task automatic test_fwd_priority();
        quiet_inputs();
        tick();
        mem_rd = 7; mem_reg_write = 1; mem_result = 32'hAA;
        wb_rd = 7;  wb_reg_write = 1;  wb_result = 32'hBB;
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1; id_rs2_data = 32'h1;
        id_rd = 0; id_reg_write = 1;
        tick();
        show("fwd_mem_over_wb");
        checks++;
        if (ex_data_b !== 32'hAA || ex_store_data !== 32'hAA) begin
            errors++;
            $display("FAIL fwd_priority: b=%h st=%h expected 000000aa", ex_data_b, ex_store_data);
        end
        mem_rd = 0; wb_rd = 0; ex_alu_result = 32'h99;
        id_rs2 = 0; id_rs2_data = 32'h1234;
        tick();
        show("fwd_x0");
        checks++;
        if (ex_data_b !== 32'h0 || ex_store_data !== 32'h0) begin
            errors++;
            $display("FAIL fwd_x0: b=%h st=%h expected 0", ex_data_b, ex_store_data);
        end
    endtask

    task automatic test_load_use();
        quiet_inputs();
        id_valid = 1; id_rd = 3; id_reg_write = 1; id_mem_read = 1;
        tick();
        show("load_x3");
        id_mem_read = 0; id_rd = 8; id_rs2 = 3; id_rs2_used = 1; id_rs2_data = 32'h5;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_ready: got %0b expected 0", id_ready);
        end
        tick();
        show("load_use_bubble");
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%0b rw=%0b expected 0 0", ex_valid, ex_reg_write);
        end
        mem_rd = 3; mem_reg_write = 1; mem_result = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: got %0b expected 1", id_ready);
        end
        tick();
        show("load_use_capture");
        checks++;
        if (ex_valid !== 1'b1 || ex_data_b !== 32'hDEAD_BEEF || ex_store_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_use_fwd: valid=%0b b=%h st=%h expected 1 deadbeef",
                     ex_valid, ex_data_b, ex_store_data);
        end
    endtask

    task automatic test_hold_flush();
        ex_t saved;
        quiet_inputs();
        id_valid = 1; id_rd = 9; id_reg_write = 1; id_mem_write = 1; id_alu_sel = 4'hC;
        id_rs1 = 1; id_rs1_data = 32'h1357; id_rs2 = 2; id_rs2_data = 32'h2468;
        tick();
        saved = dut_state();
        show("hold_base");
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            hold = 1;
            #1;
            checks++;
            if (id_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready[%0d]: got %0b expected 0", i, id_ready);
            end
            tick();
            show("hold");
            checks++;
            if (dut_state() !== saved) begin
                errors++;
                $display("FAIL hold_state[%0d]: got %h expected %h", i, dut_state(), saved);
            end
        end
        flush = 1; hold = 1;
        tick();
        show("flush_hold");
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: valid=%0b rw=%0b expected 0 0", ex_valid, ex_reg_write);
        end
    endtask

    task automatic test_operand_select();
        quiet_inputs();
        tick();
        id_valid = 1; id_use_pc = 1; id_pc = 32'h100; id_use_imm = 1; id_imm = 32'hFFFF_FFFC;
        id_rs1 = 4; id_rs1_data = 32'h4444;
        id_rs2 = 9; id_rs2_data = 32'h1;
        mem_rd = 9; mem_reg_write = 1; mem_result = 32'h55;
        tick();
        show("operand_select");
        checks++;
        if (ex_data_a !== 32'h100 || ex_data_b !== 32'hFFFF_FFFC || ex_store_data !== 32'h55) begin
            errors++;
            $display("FAIL operand_select: a=%h b=%h st=%h expected 00000100 fffffffc 00000055",
                     ex_data_a, ex_data_b, ex_store_data);
        end
    endtask

    task automatic test_random();
        ex_t m, n;
        logic exp_ready;
        quiet_inputs();
        rst = 1;
        tick();
        m = '0;
        for (int i = 0; i < 300; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            randomize_id();
            ex_alu_result = $urandom;
            mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom); mem_result = $urandom;
            wb_rd  = 5'($urandom_range(0, 3)); wb_reg_write  = 1'($urandom); wb_result  = $urandom;
            #1;
            exp_ready = !hold && !ref_load_use(m);
            checks++;
            if (id_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %0b expected %0b", i, id_ready, exp_ready);
            end
            n = ref_next(m);
            tick();
            show("random");
            checks++;
            if (dut_state() !== n) begin
                errors++;
                $display("FAIL rand_state[%0d]: got %h expected %h", i, dut_state(), n);
            end
            m = n;
        end
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_ex_forwarding();
        test_fwd_priority();
        test_load_use();
        test_hold_flush();
        test_operand_select();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Operand-staging pipeline register that sits directly upstream of the ALU. Each cycle it accepts one decoded instruction plus register-file read data, resolves data hazards by forwarding from the EX, MEM and WB stages, selects the ALU operands (register, PC or immediate), and registers them with the ALU select code into the ID/EX boundary. It also detects load-use hazards, stalls decode for one cycle, and inserts a bubble.

## Interface
- DATA_WIDTH, 32: operand and result width.
- SEL_WIDTH, 4: ALU select width.
- REG_ADDR_WIDTH, 5: register index width.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  DATA  1  combinational; decode may advance (0 during load-use stall or hold).
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  source and destination indices.
- id_rs1_used, id_rs2_used  in  1  the instruction reads rs1/rs2.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data.
- id_pc, id_imm  in  DATA_WIDTH  PC and sign-extended immediate.
- id_use_pc, id_use_imm  in  1  operand A = PC; operand B = immediate.
- id_alu_sel  in  SEL_WIDTH  ALU operation code.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- ex_alu_result  in  DATA_WIDTH  current ALU output, for the instruction held in this stage.
- mem_rd, wb_rd  in  REG_ADDR_WIDTH; mem_reg_write, wb_reg_write  in  1; mem_result, wb_result  in  DATA_WIDTH  later-stage forwarding sources.
- hold  in  1  downstream stall; freeze register.
- flush  in  1  branch/jump redirect; kill contents.
- ex_valid  out  1; ex_data_a, ex_data_b, ex_store_data  out  DATA_WIDTH; ex_alu_sel  out  SEL_WIDTH; ex_rd  out  REG_ADDR_WIDTH; ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered ID/EX contents.

## Operation
- Forwarded source value fwd_rsN, priority high to low:
  - Index 0: the value is 0. x0 is never forwarded.
  - EX: ex_valid && ex_reg_write && !ex_mem_read && ex_rd == rsN, then ex_alu_result.
  - MEM: mem_reg_write && mem_rd == rsN, then mem_result.
  - WB: wb_reg_write && wb_rd == rsN, then wb_result.
  - Otherwise: id_rsN_data.
- Operand selection:
  - ex_data_a = id_use_pc ? id_pc : fwd_rs1.
  - ex_data_b = id_use_imm ? id_imm : fwd_rs2.
  - ex_store_data = fwd_rs2.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd)) && id_valid.
- id_ready = !hold && !load_use.
- Register update each edge, first match wins:
  1. rst: all outputs 0.
  2. flush: insert a bubble (ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; data fields don't-care, driven 0). Flush overrides hold and hazard.
  3. hold: keep all outputs unchanged.
  4. load_use: insert a bubble. The decode instruction is not consumed.
  5. Otherwise: capture the selected operands and controls. ex_valid = id_valid. When !id_valid, all control bits are 0.
- Width rules: no arithmetic inside the block. Every datapath is DATA_WIDTH bits, passed unmodified.

## Timing
- Latency: one cycle from id_* to ex_*.
- Throughput: one instruction per cycle absent hazards.
- Load-use costs exactly one bubble. On the following cycle the load is in MEM and is forwarded from mem_result.
- id_ready is combinational from current ex_* registers, hold and id_*. No other output path is combinational.
- Reset mid-stream discards any held instruction. ex_valid = 0 on the first cycle after rst deasserts.
- Simultaneous flush and load_use: a bubble is inserted and id_ready follows the formula. Decode discards on flush.

## Test plan
- Reset:
  - Stimulus: rst high 2 cycles with random id_*.
  - Required: all ex_* = 0; after rst deasserts with id_valid = 0, ex_valid stays 0.
- EX forwarding:
  - Stimulus: ADD x5 captured with ALU result 0x0000_0030, then the next instruction reads rs1 = x5 with id_rs1_data = 0x11.
  - Required: ex_data_a = 0x30.
- Forwarding priority and x0:
  - Stimulus: MEM and WB both target x7 (mem_result = 0xAA, wb_result = 0xBB); the instruction reads x7, then reads x0 with all stages targeting x0.
  - Required: ex_data_b = 0xAA; then 0.
- Load-use:
  - Stimulus: load to x3 in EX, decode reads rs2 = x3.
  - Required: id_ready = 0 for one cycle and ex_valid = 0 the next cycle. The following cycle captures the instruction with fwd_rs2 = mem_result (0xDEAD_BEEF).
- Hold and flush:
  - Stimulus: hold for 3 cycles.
  - Required: ex_* unchanged and id_ready = 0.
  - Stimulus: flush and hold asserted together.
  - Required: ex_valid = 0 and ex_reg_write = 0 on the next edge.
- Operand select:
  - Stimulus: id_use_pc = 1, id_pc = 0x100, id_use_imm = 1, id_imm = 0xFFFF_FFFC, rs2 forwarded = 0x55.
  - Required: ex_data_a = 0x100, ex_data_b = 0xFFFF_FFFC, ex_store_data = 0x55.
